// File: rtl/rv32_pkg.sv
// Shared RV32 fetch types: instruction word, FIFO entry layout and the default boot PC.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef logic [XLEN-1:0] inst_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        inst_t           inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} entries with flush and same-cycle push/pop.
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    entries [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues RAM port A reads, buffers responses for decode.
module instr_fetch
    import rv32_pkg::*;
#(
    parameter int          WIDTH_BITS = 64,
    parameter int          BYTES      = 131072,
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 4,
    localparam int         ADDR_BITS  = $clog2(BYTES / (WIDTH_BITS / 8))
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    output logic                  mem_en,
    output logic [ADDR_BITS-1:0]  mem_addr,
    input  logic [WIDTH_BITS-1:0] mem_rdata,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [31:0]           inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIMIT = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic          push;
    logic          pop;
    fetch_entry_t  push_data;
    fetch_entry_t  head;

    // Credit rule: an issued read always has a FIFO slot waiting for it, so no overflow.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign mem_en      = rst_n && fetch_en && !redirect_valid && (credit_used < DEPTH_LIMIT);
    assign mem_addr    = pc[3 +: ADDR_BITS];

    always_comb begin
        push_data      = '0;
        push_data.pc   = inflight_pc;
        push_data.inst = inflight_pc[2] ? mem_rdata[63:32] : mem_rdata[31:0];
    end

    assign push       = inflight;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;

    // A redirect drops the pending RAM response by clearing inflight before it can be pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & ~32'h3;
            inflight <= 1'b0;
        end else if (mem_en) begin
            pc          <= pc + 32'd4;
            inflight    <= 1'b1;
            inflight_pc <= pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign inst    = head.inst;
    assign inst_pc = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch against a program-order reference model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        mem_en;
    logic [13:0] mem_addr;
    logic [63:0] mem_rdata = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int          tests_run = 0;
    int          failures  = 0;
    int          accepted  = 0;
    int          acc_mark;
    logic [31:0] exp_pc;
    logic [31:0] instmem [512];
    logic [63:0] ram     [256];

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    // Program image seen by RAM; addresses beyond 2 KiB alias in both RAM and model.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= ram[mem_addr[7:0]];
    end

    task checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Decode's view: program-order PCs, each accepted word is instmem[pc/4], redirect restarts.
    task checkOutput();
        if (inst_valid && inst_ready) begin
            checkVal("inst_pc", inst_pc, exp_pc);
            checkVal("inst", inst, instmem[exp_pc[10:2]]);
            exp_pc = exp_pc + 32'd4;
            accepted++;
        end
        if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
    endtask

    task applyStimulus(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        fetch_en       = fe;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        checkOutput();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) instmem[i] = $urandom;
        instmem[0] = 32'h0010_0093;
        instmem[1] = 32'h0000_0013;
        for (int w = 0; w < 256; w++) ram[w] = {instmem[2*w+1], instmem[2*w]};

        rst_n = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; exp_pc = 32'h0;

        repeat (3) @(negedge clk);
        #1;
        checkVal("rst_mem_en", 32'(mem_en), 32'd0);
        checkVal("rst_valid", 32'(inst_valid), 32'd0);
        checkVal("rst_inst", inst, 32'd0);
        checkVal("rst_inst_pc", inst_pc, 32'd0);

        // Startup latency and 16-instruction stream
        @(posedge clk); #2; rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkVal("c0_mem_en", 32'(mem_en), 32'd1);
        checkVal("c0_mem_addr", 32'(mem_addr), 32'd0);
        checkVal("c0_valid", 32'(inst_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkVal("c1_valid", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkVal("stream_valid", 32'(inst_valid), 32'd1);
            if (i == 0) checkVal("c2_inst", inst, 32'h0010_0093);
            if (i == 1) checkVal("c3_inst", inst, 32'h0000_0013);
            if (i == 1) checkVal("c3_inst_pc", inst_pc, 32'h4);
        end
        checkVal("stream_count", 32'(accepted), 32'd16);

        // Backpressure then release
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkVal("bp_mem_en", 32'(mem_en), 32'd0);
        checkVal("bp_valid", 32'(inst_valid), 32'd1);
        acc_mark = accepted;
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkVal("bp_release_count", 32'(accepted - acc_mark), 32'd12);
        checkVal("pre_redirect_issue", 32'(mem_en), 32'd1);

        // Redirect with a read in flight and a coincident handshake, twice
        for (int r = 0; r < 2; r++) begin
            acc_mark = accepted;
            applyStimulus(1'b1, 1'b1, 1'b1, (r == 0) ? 32'h100 : 32'h103);
            checkVal("redir_mem_en", 32'(mem_en), 32'd0);
            checkVal("redir_valid", 32'(inst_valid), 32'd1);
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkVal("redir_once", 32'(accepted - acc_mark), 32'd1);
            checkVal("redir_r1_mem_en", 32'(mem_en), 32'd1);
            checkVal("redir_r1_addr", 32'(mem_addr), 32'h20);
            checkVal("redir_r1_valid", 32'(inst_valid), 32'd0);
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkVal("redir_r2_valid", 32'(inst_valid), 32'd0);
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkVal("redir_r3_valid", 32'(inst_valid), 32'd1);
            checkVal("redir_r3_pc", inst_pc, 32'h100);
            for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        end

        // Asynchronous reset between edges
        #1; rst_n = 1'b0; #1;
        checkVal("areset_valid", 32'(inst_valid), 32'd0);
        checkVal("areset_mem_en", 32'(mem_en), 32'd0);
        exp_pc = 32'h0;
        @(posedge clk); #2; rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkVal("restart_addr", 32'(mem_addr), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkVal("restart_valid", 32'(inst_valid), 32'd1);
        checkVal("restart_pc", inst_pc, 32'h0);

        // Randomized traffic against the program-order model
        acc_mark = accepted;
        for (int i = 0; i < 400; i++) begin
            logic        fe;
            logic        rdy;
            logic        rv;
            logic [31:0] rpc;
            fe  = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = 32'($urandom_range(0, 2047));
            applyStimulus(fe, rdy, rv, rpc);
            if (!fe || rv) checkVal("rand_mem_en_gate", 32'(mem_en), 32'd0);
        end
        checkVal("rand_progress", 32'(accepted - acc_mark > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
